// File: rtl/seg_encoder.sv
// Seven-segment pattern to digit recovery.
// A pattern on dlg must be sampled unchanged at STABLE_CYCLES consecutive
// clock edges before it is accepted. Accepted legal patterns are decoded into
// num and offered to a consumer with a valid/ready handshake. Illegal patterns
// are flagged and counted. The blank pattern (00) is accepted silently.
//
// Handshake: out_valid=1 means num holds a result not yet consumed. A result
// is consumed at any rising edge where out_valid=1 and out_ready=1. A new legal
// acceptance at the same edge replaces it and keeps out_valid=1 without an
// overrun. A new legal acceptance while out_valid=1 and out_ready=0 overwrites
// the unconsumed result and pulses overrun.
module seg_encoder #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] dlg,
    input  logic       out_ready,
    output logic [3:0] num,
    output logic       out_valid,
    output logic       code_err,
    output logic       overrun,
    output logic [7:0] err_count
);

    // Counter saturation point and the count value seen at the accepting edge.
    localparam logic [3:0] CNT_MAX = 4'(STABLE_CYCLES - 1);
    localparam logic [3:0] CNT_ACC = 4'(STABLE_CYCLES - 2);

    typedef enum logic {
        SETTLE = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t     state;
    logic [7:0] samp;
    logic [3:0] cnt;

    logic       same;
    logic       accept;
    logic       dec_legal;
    logic [3:0] dec_num;

    assign same   = (dlg == samp);
    assign accept = same && (state == SETTLE) && (cnt == CNT_ACC);

    // Decode the incoming pattern; dec_legal marks patterns that carry a digit.
    always_comb begin
        dec_legal = 1'b1;
        dec_num   = 4'h0;
        case (dlg)
            8'h3F: dec_num = 4'h0;
            8'h06: dec_num = 4'h1;
            8'h5B: dec_num = 4'h2;
            8'h4F: dec_num = 4'h3;
            8'h66: dec_num = 4'h4;
            8'h6D: dec_num = 4'h5;
            8'h7D: dec_num = 4'h6;
            8'h07: dec_num = 4'h7;
            8'h7F: dec_num = 4'h8;
            8'h6F: dec_num = 4'h9;
            8'h80: dec_num = 4'hF;
            default: dec_legal = 1'b0;
        endcase
    end

    // Sampler, stability counter, settle/lock FSM and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            samp      <= 8'h00;
            cnt       <= 4'd0;
            state     <= SETTLE;
            num       <= 4'h0;
            out_valid <= 1'b0;
            code_err  <= 1'b0;
            overrun   <= 1'b0;
            err_count <= 8'd0;
        end else begin
            samp     <= dlg;
            code_err <= 1'b0;
            overrun  <= 1'b0;

            if (!same) begin
                cnt <= 4'd0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + 4'd1;
            end

            case (state)
                SETTLE: if (accept) state <= LOCKED;
                LOCKED: if (!same) state <= SETTLE;
                default: state <= SETTLE;
            endcase

            if (accept && dec_legal) begin
                num       <= dec_num;
                out_valid <= 1'b1;
                overrun   <= out_valid && !out_ready;
            end else begin
                // Illegal non-blank pattern: flag it; the pending result stays.
                if (accept && (dlg != 8'h00)) begin
                    code_err <= 1'b1;
                    if (err_count != 8'hFF) begin
                        err_count <= err_count + 8'd1;
                    end
                end
                if (out_valid && out_ready) begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_seg_encoder.sv
// Bench for seg_encoder: directed vector table, hand-written corner sequences
// (error saturation, asynchronous reset) and a randomized run against a
// run-length reference model.
module tb_seg_encoder;

    localparam int S = 4;

    logic       clk;
    logic       rst;
    logic [7:0] dlg;
    logic       out_ready;
    logic [3:0] num;
    logic       out_valid;
    logic       code_err;
    logic       overrun;
    logic [7:0] err_count;

    int total;
    int bad;

    seg_encoder #(.STABLE_CYCLES(S)) dut (
        .clk       (clk),
        .rst       (rst),
        .dlg       (dlg),
        .out_ready (out_ready),
        .num       (num),
        .out_valid (out_valid),
        .code_err  (code_err),
        .overrun   (overrun),
        .err_count (err_count)
    );

    // Clock and reset.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Directed vector record: drive dlg/ready for 'edges' edges, then expect.
    typedef struct {
        logic [7:0] dlg;
        logic       rdy;
        int         edges;
        logic [3:0] e_num;
        logic       e_valid;
        logic       e_cerr;
        logic       e_ovr;
        logic [7:0] e_errc;
    } vec_t;

    vec_t tbl[20];

    // Reference model state (run-length view of the input stream).
    logic [7:0] m_prev;
    int         m_run;
    logic [3:0] m_num;
    logic       m_valid;
    logic       m_cerr;
    logic       m_ovr;
    logic [7:0] m_errc;

    logic [7:0] pat_tab[11];
    logic [3:0] dig_tab[11];

    // Advance one edge, then settle away from the edge before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [14:0] act, input logic [14:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got num=%h valid=%b cerr=%b ovr=%b errc=%0d, want num=%h valid=%b cerr=%b ovr=%b errc=%0d",
                     name, act[14:11], act[10], act[9], act[8], act[7:0],
                     exp[14:11], exp[10], exp[9], exp[8], exp[7:0]);
        end
    endtask

    function automatic logic [14:0] dut_out();
        return {num, out_valid, code_err, overrun, err_count};
    endfunction

    function automatic logic [14:0] pack(input logic [3:0] n, input logic v, input logic c,
                                         input logic o, input logic [7:0] e);
        return {n, v, c, o, e};
    endfunction

    // Scoreboard expected queue, one entry per modelled edge.
    logic [14:0] exp_q[$];

    task automatic model_reset();
        m_prev  = 8'h00;
        m_run   = 1;
        m_num   = 4'h0;
        m_valid = 1'b0;
        m_cerr  = 1'b0;
        m_ovr   = 1'b0;
        m_errc  = 8'd0;
    endtask

    // One edge of the model: a pattern fires when its run reaches S samples.
    task automatic model_edge(input logic [7:0] d, input logic rdy);
        logic fire;
        logic legal;
        logic [3:0] v;
        legal = 1'b0;
        v     = 4'h0;
        if (d == m_prev) m_run = m_run + 1;
        else             m_run = 1;
        m_prev = d;
        fire = (m_run == S);
        for (int k = 0; k < 11; k++) begin
            if (pat_tab[k] == d) begin
                legal = 1'b1;
                v     = dig_tab[k];
            end
        end
        m_cerr = 1'b0;
        m_ovr  = 1'b0;
        if (fire && legal) begin
            m_ovr   = m_valid && !rdy;
            m_num   = v;
            m_valid = 1'b1;
        end else begin
            if (fire && d != 8'h00) begin
                m_cerr = 1'b1;
                if (m_errc != 8'd255) m_errc = m_errc + 8'd1;
            end
            if (m_valid && rdy) m_valid = 1'b0;
        end
        exp_q.push_back(pack(m_num, m_valid, m_cerr, m_ovr, m_errc));
    endtask

    initial begin
        total = 0;
        bad   = 0;
        pat_tab = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F, 8'h80};
        dig_tab = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hF};

        tbl[0]  = '{8'h5B, 1'b1, 3,  4'h0, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[1]  = '{8'h5B, 1'b1, 1,  4'h2, 1'b1, 1'b0, 1'b0, 8'd0};
        tbl[2]  = '{8'h5B, 1'b1, 1,  4'h2, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[3]  = '{8'h5B, 1'b1, 5,  4'h2, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[4]  = '{8'h6D, 1'b1, 3,  4'h2, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[5]  = '{8'h7D, 1'b1, 4,  4'h6, 1'b1, 1'b0, 1'b0, 8'd0};
        tbl[6]  = '{8'h7D, 1'b0, 2,  4'h6, 1'b1, 1'b0, 1'b0, 8'd0};
        tbl[7]  = '{8'h06, 1'b0, 4,  4'h1, 1'b1, 1'b0, 1'b1, 8'd0};
        tbl[8]  = '{8'h4F, 1'b0, 4,  4'h3, 1'b1, 1'b0, 1'b1, 8'd0};
        tbl[9]  = '{8'h4F, 1'b0, 1,  4'h3, 1'b1, 1'b0, 1'b0, 8'd0};
        tbl[10] = '{8'h06, 1'b0, 4,  4'h1, 1'b1, 1'b0, 1'b1, 8'd0};
        tbl[11] = '{8'h4F, 1'b0, 3,  4'h1, 1'b1, 1'b0, 1'b0, 8'd0};
        tbl[12] = '{8'h4F, 1'b1, 1,  4'h3, 1'b1, 1'b0, 1'b0, 8'd0};
        tbl[13] = '{8'h4F, 1'b1, 1,  4'h3, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[14] = '{8'h55, 1'b1, 3,  4'h3, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[15] = '{8'h55, 1'b1, 1,  4'h3, 1'b0, 1'b1, 1'b0, 8'd1};
        tbl[16] = '{8'h55, 1'b1, 1,  4'h3, 1'b0, 1'b0, 1'b0, 8'd1};
        tbl[17] = '{8'h00, 1'b1, 10, 4'h3, 1'b0, 1'b0, 1'b0, 8'd1};
        tbl[18] = '{8'h80, 1'b1, 4,  4'hF, 1'b1, 1'b0, 1'b0, 8'd1};
        tbl[19] = '{8'h80, 1'b1, 1,  4'hF, 1'b0, 1'b0, 1'b0, 8'd1};

        // Reset and reset-state check.
        rst       = 1'b1;
        dlg       = 8'h00;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_state", dut_out(), pack(4'h0, 1'b0, 1'b0, 1'b0, 8'd0));

        // Directed table.
        for (int r = 0; r < 20; r++) begin
            dlg       = tbl[r].dlg;
            out_ready = tbl[r].rdy;
            for (int e = 0; e < tbl[r].edges; e++) step();
            check($sformatf("vec%0d", r), dut_out(),
                  pack(tbl[r].e_num, tbl[r].e_valid, tbl[r].e_cerr, tbl[r].e_ovr, tbl[r].e_errc));
        end

        // Error counter saturation: 256 more illegal acceptances from a count of 1.
        out_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            dlg = (i % 2 == 1) ? 8'hAA : 8'h55;
            repeat (S) step();
            if (i == 252) check("errc_254", dut_out(), pack(4'hF, 1'b0, 1'b1, 1'b0, 8'd254));
        end
        check("errc_sat", dut_out(), pack(4'hF, 1'b0, 1'b1, 1'b0, 8'd255));
        dlg = 8'h55;
        repeat (S) step();
        check("errc_hold", dut_out(), pack(4'hF, 1'b0, 1'b1, 1'b0, 8'd255));

        // Asynchronous reset mid-settle with a pending result.
        out_ready = 1'b0;
        dlg = 8'h6F;
        repeat (S) step();
        check("pend_9", dut_out(), pack(4'h9, 1'b1, 1'b0, 1'b0, 8'd255));
        dlg = 8'h7F;
        repeat (2) step();
        #2;
        rst = 1'b1;
        #1;
        check("async_rst", dut_out(), pack(4'h0, 1'b0, 1'b0, 1'b0, 8'd0));
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (S - 1) step();
        check("rst_resettle", dut_out(), pack(4'h0, 1'b0, 1'b0, 1'b0, 8'd0));
        step();
        check("rst_accept_8", dut_out(), pack(4'h8, 1'b1, 1'b0, 1'b0, 8'd0));

        // Randomized run against the reference model.
        rst = 1'b1;
        dlg = 8'h00;
        out_ready = 1'b0;
        step();
        rst = 1'b0;
        model_reset();
        for (int seg = 0; seg < 400; seg++) begin
            int sel;
            int hold;
            logic [7:0] p;
            sel = $urandom_range(0, 15);
            if (sel < 11)       p = pat_tab[sel];
            else if (sel == 11) p = 8'h00;
            else                p = 8'($urandom_range(0, 255));
            hold = $urandom_range(1, 6);
            for (int e = 0; e < hold; e++) begin
                dlg       = p;
                out_ready = 1'($urandom_range(0, 1));
                model_edge(dlg, out_ready);
                step();
                check($sformatf("rand%0d_%0d", seg, e), dut_out(), exp_q.pop_front());
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
